// File: rtl/dcache_if.sv
// CPU load/store port and backing-memory port of the data cache.
// slave is the cache's view; master is the CPU/memory side driving it.
interface dcache_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic [1:0]  width;
    logic        flush;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ack;

    modport slave (
        input  addr, wdata, re, we, width, flush, mem_rdata, mem_valid, mem_ack,
        output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output addr, wdata, re, we, width, flush, mem_rdata, mem_valid, mem_ack,
        input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache (4-word lines).
// Loads refill a whole line in 4 in-order beats; stores always go to memory.
module dcache #(
    parameter int SETS  = 16,
    parameter int WORDS = 4
) (
    input logic     clk,
    input logic     rst,
    dcache_if.slave bus
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                           state;
    logic [1:0]                       cnt;
    logic [SETS-1:0]                  valid;
    logic [SETS-1:0][TW-1:0]          tags;
    logic [SETS-1:0][WORDS-1:0][31:0] data;

    logic [IW-1:0] idx, midx;
    logic [TW-1:0] tag, mtag;
    logic [1:0]    off, moff;
    logic          hit, mhit;
    logic [3:0]    be_c;
    logic [31:0]   wd_c;
    logic          stall_c;

    // CPU-side lookup uses the live address; refill/write-back use the captured one
    assign idx  = bus.addr[IW+3:4];
    assign tag  = bus.addr[31:IW+4];
    assign off  = bus.addr[3:2];
    assign midx = bus.mem_addr[IW+3:4];
    assign mtag = bus.mem_addr[31:IW+4];
    assign moff = bus.mem_addr[3:2];
    assign hit  = valid[idx] && (tags[idx] == tag);
    assign mhit = valid[midx] && (tags[midx] == mtag);

    assign bus.rdata = data[idx][off];
    assign bus.stall = stall_c;

    always_comb begin
        be_c = 4'b1111;
        wd_c = bus.wdata;
        case (bus.width)
            2'b00: begin
                be_c = 4'b0001 << bus.addr[1:0];
                wd_c = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be_c = 4'b0011 << {bus.addr[1], 1'b0};
                wd_c = {2{bus.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_c = 1'b0;
        case (state)
            IDLE:    stall_c = bus.we || (bus.re && !hit);
            REFILL:  stall_c = 1'b1;
            WRITE:   stall_c = !bus.mem_ack;
            default: stall_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            valid         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.we) begin
                        state         <= WRITE;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= {bus.addr[31:2], 2'b00};
                        bus.mem_wdata <= wd_c;
                        bus.mem_be    <= be_c;
                    end else if (bus.re && !hit) begin
                        state        <= REFILL;
                        cnt          <= 2'd0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= {bus.addr[31:4], 4'b0000};
                    end else if (bus.flush) begin
                        valid <= '0;
                    end
                end
                REFILL: begin
                    if (bus.mem_valid) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            valid[midx] <= 1'b1;
                            state       <= IDLE;
                            bus.mem_req <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage is not reset; valid bits alone decide whether it is usable
    always_ff @(posedge clk) begin
        if (state == REFILL && bus.mem_valid) begin
            data[midx][cnt] <= bus.mem_rdata;
            if (cnt == 2'd3)
                tags[midx] <= mtag;
        end
        if (state == WRITE && bus.mem_ack && mhit) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b])
                    data[midx][moff][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: inline memory responder, a word-level memory
// model, and scoreboard queues for expected load data and memory writes.
module tb_dcache;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_if bus ();
    dcache #(.SETS(16), .WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    logic [31:0] mem[logic [31:0]];

    function automatic logic [31:0] model(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem.exists(wa)) return mem[wa];
        return {16'hC0DE, wa[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load: entered and left 1 unit after an edge. gap = idle cycles before the first beat.
    task automatic load(input logic [31:0] a, input bit miss, input int gap);
        int stalls;
        int b;
        int cyc;
        logic [31:0] line;
        line = {a[31:4], 4'b0000};
        bus.addr = a; bus.re = 1'b1; bus.we = 1'b0;
        rd_q.push_back(model(a));
        stalls = 0;
        #1;
        chk("ld_miss_detect", {31'b0, bus.stall}, {31'b0, miss});
        if (bus.stall) begin
            stalls = 1;
            @(posedge clk); #1;
            b = 0; cyc = 0;
            while (b < 4 && cyc < 20) begin
                bus.mem_valid = (cyc >= gap);
                bus.mem_rdata = model(line + 32'(4 * b));
                #1;
                if (cyc == 0) begin
                    chk("rf_mem_req", {31'b0, bus.mem_req}, 32'd1);
                    chk("rf_mem_we", {31'b0, bus.mem_we}, 32'd0);
                    chk("rf_mem_addr", bus.mem_addr, line);
                end
                if (bus.stall) stalls++;
                if (bus.mem_valid) b++;
                cyc++;
                @(posedge clk); #1;
            end
            bus.mem_valid = 1'b0;
            chk("ld_stall_cycles", 32'(stalls), 32'(1 + gap + 4));
            #1;
        end
        chk("ld_stall_released", {31'b0, bus.stall}, 32'd0);
        if (rd_q.size() == 0) chk("ld_queue_empty", 32'd1, 32'd0);
        else chk("ld_rdata", bus.rdata, rd_q.pop_front());
        @(posedge clk); #1;
        bus.re = 1'b0;
    endtask

    // Store: ack arrives on WRITE cycle number ackdly (0 = first WRITE cycle).
    task automatic store(input logic [31:0] a, input logic [31:0] v, input logic [1:0] w,
                         input int ackdly);
        wr_t e;
        int stalls;
        int cyc;
        logic [31:0] old;
        e.a = {a[31:2], 2'b00};
        case (w)
            2'b00: begin
                e.be = 4'b0001 << a[1:0];
                e.d  = {4{v[7:0]}};
            end
            2'b01: begin
                e.be = a[1] ? 4'b1100 : 4'b0011;
                e.d  = {2{v[15:0]}};
            end
            default: begin
                e.be = 4'b1111;
                e.d  = v;
            end
        endcase
        wr_q.push_back(e);
        old = model(a);
        for (int l = 0; l < 4; l++)
            if (e.be[l]) old[8*l +: 8] = e.d[8*l +: 8];
        mem[e.a] = old;

        bus.addr = a; bus.wdata = v; bus.width = w; bus.we = 1'b1; bus.re = 1'b0;
        #1;
        chk("st_stall_idle", {31'b0, bus.stall}, 32'd1);
        stalls = 1;
        @(posedge clk); #1;
        cyc = 0;
        while (cyc < 20) begin
            bus.mem_ack = (cyc == ackdly);
            #1;
            if (cyc == 0) begin
                e = wr_q.pop_front();
                chk("wr_mem_req", {31'b0, bus.mem_req}, 32'd1);
                chk("wr_mem_we", {31'b0, bus.mem_we}, 32'd1);
                chk("wr_mem_addr", bus.mem_addr, e.a);
                chk("wr_mem_wdata", bus.mem_wdata, e.d);
                chk("wr_mem_be", {28'b0, bus.mem_be}, {28'b0, e.be});
            end
            if (bus.stall) stalls++;
            @(posedge clk); #1;
            if (bus.mem_ack) break;
            cyc++;
        end
        bus.mem_ack = 1'b0;
        bus.we = 1'b0;
        chk("st_stall_cycles", 32'(stalls), 32'(1 + ackdly));
        #1;
        chk("st_done_req", {31'b0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.re = 1'b0; bus.we = 1'b0;
        bus.width = 2'b10; bus.flush = 1'b0;
        bus.mem_rdata = '0; bus.mem_valid = 1'b0; bus.mem_ack = 1'b0;
        mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1;
        mem[32'h108] = 32'hA2; mem[32'h10C] = 32'hA3;

        tick(); tick();
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
        rst = 1'b1;
        tick();

        // Fill, then hit on the last word
        load(32'h100, 1'b1, 0);
        chk("first_fill_word0", model(32'h100), 32'hA0);
        load(32'h10C, 1'b0, 0);

        // Byte store into the cached line, then read the merged word
        store(32'h101, 32'h0000_00EE, 2'b00, 2);
        load(32'h100, 1'b0, 0);
        chk("byte_merge_const", bus.rdata, 32'h0000_EEA0);

        // Half store, ack on first WRITE cycle; word store with width 11
        store(32'h106, 32'h0000_1234, 2'b01, 0);
        load(32'h104, 1'b0, 0);
        store(32'h108, 32'hCAFE_F00D, 2'b11, 1);
        load(32'h108, 1'b0, 0);

        // Store miss writes through without allocating
        store(32'h200, 32'h1357_9BDF, 2'b10, 1);
        load(32'h200, 1'b1, 1);

        // Alias on index 0 evicts line 0x100
        load(32'h1100, 1'b1, 2);
        load(32'h100, 1'b1, 0);
        load(32'h10C, 1'b0, 0);

        // Flush invalidates everything
        bus.flush = 1'b1;
        #1;
        chk("flush_no_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        load(32'h100, 1'b1, 0);

        // Reset in the middle of a refill abandons the burst
        bus.addr = 32'h140; bus.re = 1'b1;
        #1;
        chk("rstmid_miss", {31'b0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 32'hBAD0_0000 | 32'(b);
            @(posedge clk); #1;
        end
        bus.mem_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstmid_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rstmid_mem_addr", bus.mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.re = 1'b0;
        @(posedge clk); #1;
        load(32'h140, 1'b1, 0);
        load(32'h144, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store path (ALU address, register store data, MemWrite, DataWidth) and a slower backing data memory. It holds 16 lines of 4 words and returns the full aligned 32-bit word; byte/half extraction and sign extension stay downstream in the CPU. It raises `stall` while a miss refill or a write-through is outstanding, and the CPU freezes PC and register writes while `stall` is high.

## Interface
- `SETS`, 16: number of lines (power of two); index = `addr[3+log2(SETS):4]`, tag = remaining upper bits.
- `WORDS`, 4: words per line; fixed at 4; offset = `addr[3:2]`.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `addr` input 32: CPU byte address.
- `wdata` input 32: CPU store data, LSB-aligned (byte in [7:0], half in [15:0]).
- `re` input 1: load request.
- `we` input 1: store request.
- `width` input 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `flush` input 1: invalidate all lines.
- `rdata` output 32: aligned word at `{addr[31:2],2'b00}`.
- `stall` output 1: CPU must hold its request and not advance.
- `mem_req` output 1: memory request active.
- `mem_we` output 1: 1 write, 0 line read.
- `mem_addr` output 32: line base (reads) or word address (writes).
- `mem_wdata` output 32: store data shifted to lane position.
- `mem_be` output 4: byte enables for writes.
- `mem_rdata` input 32: refill beat data.
- `mem_valid` input 1: refill beat valid; beats arrive in order, words 0..3.
- `mem_ack` input 1: write accepted; single-cycle pulse.

## Operation
- State per line: `valid`, tag, 4 data words. The FSM has three states: IDLE, REFILL, WRITE.
- Hit: `valid[index] && tag match`. `rdata` is driven combinationally from the data array at `index/offset` in every state.
- Byte enables:
  - byte: `1 << addr[1:0]`.
  - half: `4'b0011 << {addr[1],1'b0}`; `addr[0]` is ignored.
  - word: `4'b1111`; `addr[1:0]` is ignored.
  - `mem_wdata` replicates the byte or half into the selected lanes.
- `we` and `re` both high: the request is treated as a store.
- IDLE:
  - `we`: capture the address, lane data and byte enables into registers, set `stall`=1, and go to WRITE.
  - `re` with a miss: capture the line base, clear the beat counter, set `stall`=1, and go to REFILL.
  - `re` with a hit, or no request: `stall`=0.
  - `flush` (only honoured in IDLE with no `we`/`re` miss): clear all `valid` on the next edge; `stall`=0.
- REFILL:
  - Outputs: `mem_req`=1, `mem_we`=0, `mem_addr`=line base, `stall`=1.
  - Each `mem_valid` writes `mem_rdata` into word[counter] and increments the 2-bit counter.
  - On the 4th beat: set the tag, set `valid`, go to IDLE.
  - The re-presented load then hits in IDLE with `stall`=0.
- WRITE:
  - Outputs: `mem_req`=1, `mem_we`=1, registered `mem_addr`/`mem_wdata`/`mem_be`.
  - `stall`=1 while `mem_ack`=0; `stall`=0 in the cycle `mem_ack`=1.
  - On the ack edge: if the line hits, merge the enabled bytes into the cached word; return to IDLE. A store miss never allocates.
- `flush` in REFILL or WRITE is ignored; the CPU holds it stalled and it is taken on return to IDLE.

## Timing
- Reset values: `stall`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, all `valid`=0, state IDLE, counter 0.
- `rdata` is combinational. The data array is not reset, so `rdata` is undefined until a line is valid.
- Load hit: 0 stall cycles.
- Load miss: stall lasts 1 (IDLE) + N cycles until the 4th `mem_valid` inclusive. The load completes in the following cycle with `stall`=0.
- Store: stall lasts 1 (IDLE) + cycles until `mem_ack`, excluding the ack cycle. Minimum 1 stall cycle if ack arrives in the first WRITE cycle.
- `mem_req` and `mem_addr` are stable from entry to REFILL/WRITE until exit.
- `mem_valid`/`mem_ack` outside the matching state are ignored.
- Reset asserted mid-REFILL or mid-WRITE: immediate return to reset values. The partial line stays invalid, and the burst is abandoned (the memory shares `rst`).
- Counter wrap 3→0 coincides with the REFILL exit.

## Test plan
- Reset, then load `0x100`:
  - Required: `stall`=1, `mem_req`=1, `mem_addr`=`0x100`.
  - Feed beats `0xA0..0xA3` → `stall` drops the cycle after the 4th beat, `rdata`=`0xA0`.
  - Load `0x10C` → hit, `rdata`=`0xA3`, 0 stalls.
- Store byte `0xEE` to `0x101` (hit line) with ack after 2 cycles:
  - Required: `mem_be`=`0010`, `mem_wdata`=`0xEEEEEEEE`, stall released on the ack cycle.
  - Then load `0x100` → `rdata`=`0x0000EEA0`.
- Store word to `0x200` (miss) → a memory write occurs; a load of `0x200` afterwards misses (no allocate).
- Alias: fill line `0x100`, then load `0x1100` (same index, different tag) → refill replaces the line; reloading `0x100` misses.
- `flush` in IDLE after fills → next load of `0x100` misses.
- Assert `rst` after 2 refill beats → `mem_req`=0 immediately; the subsequent load of the same address misses and refills all 4 beats.
